// File: rtl/arp_responder_multi.sv
// ARP engine: checks RX ARP requests against up to N_IP local IPv4 addresses and writes a
// 42-byte reply, or a gratuitous ARP announcement, into the TX packet buffer.
module arp_responder_multi #(
   parameter int ADDR_W = 6,
   parameter int RD_LAT = 2,
   parameter int N_IP   = 2
) (
   input  logic                mac_clk,
   input  logic                reset,
   input  logic                packet_ready,
   output logic                done_with_packet,
   input  logic [7:0]          packet_data,
   output logic [ADDR_W-1:0]   packet_read_addr,
   input  logic [47:0]         myMAC,
   input  logic [32*N_IP-1:0]  myIP,
   input  logic [N_IP-1:0]     ip_valid,
   input  logic                garp_req,
   input  logic [1:0]          garp_idx,
   output logic [7:0]          packet_out,
   output logic [ADDR_W-1:0]   packet_out_addr,
   output logic                packet_out_we,
   output logic                packet_xmit,
   output logic [15:0]         rx_ok_cnt,
   output logic [15:0]         rx_drop_cnt
);
   typedef enum logic [2:0] {IDLE, CHK_CONST, CHK_IP, BUILD, DONE, PREIDLE} state_t;

   // Per-byte cycle counter: data is sampled at LAST_RD, the TX strobe occupies LAST_WR.
   localparam logic [2:0] LAST_RD = 3'(RD_LAT);
   localparam logic [2:0] LAST_WR = 3'(RD_LAT + 1);

   function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [5:0] j);
      case (j)
         6'd0:    mac_byte = mac[47:40];
         6'd1:    mac_byte = mac[39:32];
         6'd2:    mac_byte = mac[31:24];
         6'd3:    mac_byte = mac[23:16];
         6'd4:    mac_byte = mac[15:8];
         default: mac_byte = mac[7:0];
      endcase
   endfunction

   function automatic logic [7:0] ip_byte(input logic [31:0] ip, input logic [5:0] j);
      case (j)
         6'd0:    ip_byte = ip[31:24];
         6'd1:    ip_byte = ip[23:16];
         6'd2:    ip_byte = ip[15:8];
         default: ip_byte = ip[7:0];
      endcase
   endfunction

   // Fixed header bytes 12..21; op_req selects opcode 1 (request/announce) or 2 (reply).
   function automatic logic [7:0] hdr_byte(input logic [5:0] b, input logic op_req);
      case (b)
         6'd12:   hdr_byte = 8'h08;
         6'd13:   hdr_byte = 8'h06;
         6'd14:   hdr_byte = 8'h00;
         6'd15:   hdr_byte = 8'h01;
         6'd16:   hdr_byte = 8'h08;
         6'd17:   hdr_byte = 8'h00;
         6'd18:   hdr_byte = 8'h06;
         6'd19:   hdr_byte = 8'h04;
         6'd20:   hdr_byte = 8'h00;
         6'd21:   hdr_byte = op_req ? 8'h01 : 8'h02;
         default: hdr_byte = 8'h00;
      endcase
   endfunction

   function automatic logic rx_used(input logic [5:0] b);
      rx_used = (b < 6'd6) || ((b >= 6'd32) && (b <= 6'd41));
   endfunction

   function automatic logic [5:0] rx_src(input logic [5:0] b);
      rx_src = (b < 6'd6) ? (b + 6'd6) : (b - 6'd10);
   endfunction

   state_t            state_q, state_d;
   logic [5:0]        byte_q, byte_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [N_IP-1:0]   mask_q, mask_d;
   logic              garp_mode_q, garp_mode_d;
   logic [1:0]        sel_q, sel_d;
   logic              garp_pend_q, garp_pend_d;
   logic [1:0]        garp_idx_q, garp_idx_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [7:0]        out_q, out_d;
   logic [ADDR_W-1:0] out_addr_q, out_addr_d;
   logic              we_q, we_d;
   logic              done_q, done_d;
   logic              xmit_q, xmit_d;
   logic [15:0]       ok_q, ok_d;
   logic [15:0]       drop_q, drop_d;

   logic [31:0]       ip_arr [N_IP];
   logic [N_IP-1:0]   ip_miss;
   logic [N_IP-1:0]   ip_mask_next;
   logic [31:0]       ip_sel;
   logic [1:0]        match_idx;
   logic              garp_ok;
   logic [7:0]        tx_byte;

   generate
      for (genvar gi = 0; gi < N_IP; gi++) begin : g_ip
         assign ip_arr[gi]  = myIP[32*gi +: 32];
         assign ip_miss[gi] = (packet_data != ip_byte(ip_arr[gi], byte_q - 6'd38));
      end
   endgenerate

   assign ip_mask_next = mask_q & ~ip_miss;

   always_comb begin
      ip_sel    = ip_arr[0];
      garp_ok   = 1'b0;
      match_idx = 2'd0;
      for (int k = 0; k < N_IP; k++) begin
         if (sel_q == 2'(k)) ip_sel = ip_arr[k];
         if ((garp_idx_q == 2'(k)) && ip_valid[k]) garp_ok = 1'b1;
      end
      for (int k = N_IP - 1; k >= 0; k--) begin
         if (ip_mask_next[k]) match_idx = 2'(k);
      end
   end

   always_comb begin
      tx_byte = 8'h00;
      if (byte_q < 6'd6)       tx_byte = garp_mode_q ? 8'hFF : packet_data;
      else if (byte_q < 6'd12) tx_byte = mac_byte(myMAC, byte_q - 6'd6);
      else if (byte_q < 6'd22) tx_byte = hdr_byte(byte_q, garp_mode_q);
      else if (byte_q < 6'd28) tx_byte = mac_byte(myMAC, byte_q - 6'd22);
      else if (byte_q < 6'd32) tx_byte = ip_byte(ip_sel, byte_q - 6'd28);
      else if (byte_q < 6'd38) tx_byte = garp_mode_q ? 8'h00 : packet_data;
      else                     tx_byte = garp_mode_q ? ip_byte(ip_sel, byte_q - 6'd38) : packet_data;
   end

   always_comb begin
      state_d     = state_q;
      byte_d      = byte_q;
      cnt_d       = cnt_q;
      mask_d      = mask_q;
      garp_mode_d = garp_mode_q;
      sel_d       = sel_q;
      garp_pend_d = garp_pend_q;
      garp_idx_d  = garp_idx_q;
      rd_addr_d   = rd_addr_q;
      out_d       = out_q;
      out_addr_d  = out_addr_q;
      we_d        = 1'b0;
      done_d      = 1'b0;
      xmit_d      = 1'b0;
      ok_d        = ok_q;
      drop_d      = drop_q;
      case (state_q)
         IDLE: begin
            if (packet_ready) begin
               state_d     = CHK_CONST;
               byte_d      = 6'd14;
               cnt_d       = 3'd0;
               mask_d      = ip_valid;
               garp_mode_d = 1'b0;
            end else if (garp_pend_q) begin
               garp_pend_d = 1'b0;
               if (garp_ok) begin
                  state_d     = BUILD;
                  byte_d      = 6'd0;
                  cnt_d       = 3'd0;
                  garp_mode_d = 1'b1;
                  sel_d       = garp_idx_q;
               end
            end
         end
         CHK_CONST: begin
            if (cnt_q == LAST_RD) begin
               cnt_d = 3'd0;
               if (packet_data != hdr_byte(byte_q, 1'b1)) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  drop_d  = drop_q + 16'd1;
               end else if (byte_q == 6'd21) begin
                  state_d = CHK_IP;
                  byte_d  = 6'd38;
               end else begin
                  byte_d = byte_q + 6'd1;
               end
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         CHK_IP: begin
            if (cnt_q == LAST_RD) begin
               cnt_d  = 3'd0;
               mask_d = ip_mask_next;
               if (ip_mask_next == '0) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  drop_d  = drop_q + 16'd1;
               end else if (byte_q == 6'd41) begin
                  state_d = BUILD;
                  byte_d  = 6'd0;
                  sel_d   = match_idx;
               end else begin
                  byte_d = byte_q + 6'd1;
               end
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         BUILD: begin
            if (cnt_q == LAST_RD) begin
               out_d      = tx_byte;
               out_addr_d = ADDR_W'(byte_q);
               we_d       = 1'b1;
               cnt_d      = cnt_q + 3'd1;
            end else if (cnt_q == LAST_WR) begin
               cnt_d = 3'd0;
               if (byte_q == 6'd41) begin
                  state_d = DONE;
                  xmit_d  = 1'b1;
                  done_d  = !garp_mode_q;
                  if (!garp_mode_q) ok_d = ok_q + 16'd1;
               end else begin
                  byte_d = byte_q + 6'd1;
               end
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         DONE:    state_d = PREIDLE;
         PREIDLE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Read address follows the byte about to be worked on; GARP frames never read RX.
      if ((state_d == CHK_CONST) || (state_d == CHK_IP))
         rd_addr_d = ADDR_W'(byte_d);
      else if ((state_d == BUILD) && !garp_mode_d && rx_used(byte_d))
         rd_addr_d = ADDR_W'(rx_src(byte_d));
      if (garp_req) begin
         garp_pend_d = 1'b1;
         garp_idx_d  = garp_idx;
      end
   end

   always_ff @(posedge mac_clk) begin
      if (reset) begin
         state_q     <= IDLE;
         byte_q      <= '0;
         cnt_q       <= '0;
         mask_q      <= '0;
         garp_mode_q <= 1'b0;
         sel_q       <= '0;
         garp_pend_q <= 1'b0;
         garp_idx_q  <= '0;
         rd_addr_q   <= '0;
         out_q       <= '0;
         out_addr_q  <= '0;
         we_q        <= 1'b0;
         done_q      <= 1'b0;
         xmit_q      <= 1'b0;
         ok_q        <= '0;
         drop_q      <= '0;
      end else begin
         state_q     <= state_d;
         byte_q      <= byte_d;
         cnt_q       <= cnt_d;
         mask_q      <= mask_d;
         garp_mode_q <= garp_mode_d;
         sel_q       <= sel_d;
         garp_pend_q <= garp_pend_d;
         garp_idx_q  <= garp_idx_d;
         rd_addr_q   <= rd_addr_d;
         out_q       <= out_d;
         out_addr_q  <= out_addr_d;
         we_q        <= we_d;
         done_q      <= done_d;
         xmit_q      <= xmit_d;
         ok_q        <= ok_d;
         drop_q      <= drop_d;
      end
   end

   assign done_with_packet = done_q;
   assign packet_read_addr = rd_addr_q;
   assign packet_out       = out_q;
   assign packet_out_addr  = out_addr_q;
   assign packet_out_we    = we_q;
   assign packet_xmit      = xmit_q;
   assign rx_ok_cnt        = ok_q;
   assign rx_drop_cnt      = drop_q;
endmodule

// File: tb/tb_arp_responder_multi.sv
// Directed bench for arp_responder_multi: three instances (RD_LAT 2, 1, 4) share one RX
// frame memory; instance 0 runs the full sequence, the others repeat the basic reply.
module tb_arp_responder_multi;
   logic             mac_clk = 1'b0;
   logic             reset;
   logic [2:0]       pr_v, done_v, we_v, xmit_v, garp_req_v;
   logic [2:0][7:0]  pdata_v, out_v;
   logic [2:0][5:0]  rd_addr_v, out_addr_v;
   logic [2:0][15:0] ok_v, drop_v;
   logic [47:0]      my_mac = 48'h0A0B0C0D0E0F;
   logic [63:0]      my_ip  = {32'hC0A80020, 32'hC0A80010};
   logic [1:0]       ip_valid, garp_idx;

   logic [7:0] rx_mem [64];
   logic [7:0] tx_mem [3][64];
   int we_cnt [3]   = '{0, 0, 0};
   int done_cnt [3] = '{0, 0, 0};
   int xmit_cnt [3] = '{0, 0, 0};
   int ev_log [64];
   int ev_n = 0;
   int n_cmp = 0;
   int n_bad = 0;
   int s_we, s_done, s_xmit, s_ev;

   logic [7:0] req_frame [42] = '{
      8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
      8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01,
      8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h00, 8'h05,
      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC0, 8'hA8, 8'h00, 8'h20};
   logic [7:0] exp_reply [42] = '{
      8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F,
      8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h02,
      8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'hC0, 8'hA8, 8'h00, 8'h20,
      8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h00, 8'h05};
   logic [7:0] exp_garp [42] = '{
      8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F,
      8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01,
      8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'hC0, 8'hA8, 8'h00, 8'h20,
      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC0, 8'hA8, 8'h00, 8'h20};

   always #5 mac_clk = ~mac_clk;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_dut
         localparam int LAT = (gi == 0) ? 2 : ((gi == 1) ? 1 : 4);
         logic [5:0] pipe [LAT];
         // RX buffer model: data for an address appears LAT cycles after it is driven
         always @(posedge mac_clk) begin
            pipe[0] <= rd_addr_v[gi];
            for (int j = 1; j < LAT; j++) pipe[j] <= pipe[j-1];
         end
         assign pdata_v[gi] = rx_mem[pipe[LAT-1]];

         arp_responder_multi #(.ADDR_W(6), .RD_LAT(LAT), .N_IP(2)) u_dut (
            .mac_clk          (mac_clk),
            .reset            (reset),
            .packet_ready     (pr_v[gi]),
            .done_with_packet (done_v[gi]),
            .packet_data      (pdata_v[gi]),
            .packet_read_addr (rd_addr_v[gi]),
            .myMAC            (my_mac),
            .myIP             (my_ip),
            .ip_valid         (ip_valid),
            .garp_req         (garp_req_v[gi]),
            .garp_idx         (garp_idx),
            .packet_out       (out_v[gi]),
            .packet_out_addr  (out_addr_v[gi]),
            .packet_out_we    (we_v[gi]),
            .packet_xmit      (xmit_v[gi]),
            .rx_ok_cnt        (ok_v[gi]),
            .rx_drop_cnt      (drop_v[gi])
         );
      end
   endgenerate

   // TX buffer model and pulse log; event kinds: 0 = drop, 1 = reply, 2 = announcement
   always @(negedge mac_clk) begin
      for (int i = 0; i < 3; i++) begin
         if (we_v[i]) begin
            tx_mem[i][out_addr_v[i]] <= out_v[i];
            we_cnt[i] <= we_cnt[i] + 1;
         end
         if (done_v[i]) done_cnt[i] <= done_cnt[i] + 1;
         if (xmit_v[i]) xmit_cnt[i] <= xmit_cnt[i] + 1;
      end
      if ((done_v[0] || xmit_v[0]) && (ev_n < 64)) begin
         ev_log[ev_n] <= done_v[0] ? (xmit_v[0] ? 1 : 0) : 2;
         ev_n <= ev_n + 1;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic snap(input int i);
      s_we   = we_cnt[i];
      s_done = done_cnt[i];
      s_xmit = xmit_cnt[i];
      s_ev   = ev_n;
   endtask

   task automatic wait_done(input int i);
      bit seen = 1'b0;
      for (int n = 0; (n < 3000) && !seen; n++) begin
         @(negedge mac_clk);
         if (done_v[i]) seen = 1'b1;
      end
      check($sformatf("done_wait%0d", i), 64'(seen), 64'd1);
   endtask

   task automatic wait_xmit(input int i);
      bit seen = 1'b0;
      for (int n = 0; (n < 3000) && !seen; n++) begin
         @(negedge mac_clk);
         if (xmit_v[i]) seen = 1'b1;
      end
      check($sformatf("xmit_wait%0d", i), 64'(seen), 64'd1);
   endtask

   task automatic garp_pulse(input logic [1:0] idx);
      garp_idx = idx;
      garp_req_v[0] = 1'b1;
      @(negedge mac_clk);
      garp_req_v[0] = 1'b0;
   endtask

   task automatic run_frame(input int i);
      pr_v[i] = 1'b1;
      wait_done(i);
      pr_v[i] = 1'b0;
      repeat (4) @(negedge mac_clk);
      $display("inst %0d frame: ok_cnt=%0d drop_cnt=%0d we=%0d", i, ok_v[i], drop_v[i], we_cnt[i] - s_we);
   endtask

   task automatic check_tx(input int i, input bit garp);
      for (int b = 0; b < 42; b++)
         check($sformatf("tx%0d_b%0d", i, b), 64'(tx_mem[i][b]), 64'(garp ? exp_garp[b] : exp_reply[b]));
   endtask

   task automatic check_deltas(input int i, input string tag, input int we_d, input int done_d, input int xmit_d);
      repeat (2) @(negedge mac_clk);
      check({tag, "_we"},   64'(we_cnt[i] - s_we),     64'(we_d));
      check({tag, "_done"}, 64'(done_cnt[i] - s_done), 64'(done_d));
      check({tag, "_xmit"}, 64'(xmit_cnt[i] - s_xmit), 64'(xmit_d));
   endtask

   initial begin
      reset = 1'b1;
      pr_v = '0;
      garp_req_v = '0;
      garp_idx = 2'd0;
      ip_valid = 2'b11;
      for (int b = 0; b < 64; b++) rx_mem[b] = (b < 42) ? req_frame[b] : 8'h00;
      repeat (5) @(negedge mac_clk);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("rst_done%0d", i), 64'(done_v[i]), 64'd0);
         check($sformatf("rst_xmit%0d", i), 64'(xmit_v[i]), 64'd0);
         check($sformatf("rst_we%0d", i), 64'(we_v[i]), 64'd0);
         check($sformatf("rst_raddr%0d", i), 64'(rd_addr_v[i]), 64'd0);
         check($sformatf("rst_ok%0d", i), 64'(ok_v[i]), 64'd0);
         check($sformatf("rst_drop%0d", i), 64'(drop_v[i]), 64'd0);
      end
      reset = 1'b0;
      repeat (3) @(negedge mac_clk);

      // valid request for .20 answered with IP1
      snap(0);
      run_frame(0);
      check_deltas(0, "t1", 42, 1, 1);
      check_tx(0, 1'b0);
      check("t1_ok", 64'(ok_v[0]), 64'd1);
      check("t1_drop", 64'(drop_v[0]), 64'd0);

      // opcode 2 in the received frame is rejected
      rx_mem[21] = 8'h02;
      snap(0);
      run_frame(0);
      check_deltas(0, "t2", 0, 1, 0);
      check("t2_drop", 64'(drop_v[0]), 64'd1);
      rx_mem[21] = 8'h01;

      // target .10 only matches entry 0, which is disabled; fails at byte 41
      rx_mem[41] = 8'h10;
      ip_valid = 2'b10;
      snap(0);
      run_frame(0);
      check_deltas(0, "t3", 0, 1, 0);
      check("t3_drop", 64'(drop_v[0]), 64'd2);
      check("t3_ok", 64'(ok_v[0]), 64'd1);
      rx_mem[41] = 8'h20;
      ip_valid = 2'b11;

      // two announcement requests during a frame merge into one, sent after the reply
      snap(0);
      pr_v[0] = 1'b1;
      repeat (10) @(negedge mac_clk);
      garp_pulse(2'd1);
      repeat (5) @(negedge mac_clk);
      garp_pulse(2'd1);
      wait_done(0);
      pr_v[0] = 1'b0;
      wait_xmit(0);
      repeat (200) @(negedge mac_clk);
      $display("inst 0 reply+announce: ok_cnt=%0d events=%0d", ok_v[0], ev_n - s_ev);
      check_deltas(0, "t4", 84, 1, 2);
      check("t4_nev", 64'(ev_n - s_ev), 64'd2);
      check("t4_ev0", 64'(ev_log[s_ev]), 64'd1);
      check("t4_ev1", 64'(ev_log[s_ev + 1]), 64'd2);
      check_tx(0, 1'b1);
      check("t4_ok", 64'(ok_v[0]), 64'd2);

      // ready frame and pending announcement together in IDLE: reply wins
      snap(0);
      pr_v[0] = 1'b1;
      repeat (10) @(negedge mac_clk);
      garp_pulse(2'd0);
      wait_done(0);
      wait_done(0);
      pr_v[0] = 1'b0;
      wait_xmit(0);
      repeat (200) @(negedge mac_clk);
      $display("inst 0 two replies+announce: ok_cnt=%0d events=%0d", ok_v[0], ev_n - s_ev);
      check("t5_nev", 64'(ev_n - s_ev), 64'd3);
      check("t5_ev0", 64'(ev_log[s_ev]), 64'd1);
      check("t5_ev1", 64'(ev_log[s_ev + 1]), 64'd1);
      check("t5_ev2", 64'(ev_log[s_ev + 2]), 64'd2);
      check("t5_ok", 64'(ok_v[0]), 64'd4);
      check("t5_dst", 64'(tx_mem[0][0]), 64'hFF);
      check("t5_op", 64'(tx_mem[0][21]), 64'h01);
      check("t5_spa", 64'({tx_mem[0][28], tx_mem[0][29], tx_mem[0][30], tx_mem[0][31]}), 64'hC0A80010);
      check("t5_tpa", 64'({tx_mem[0][38], tx_mem[0][39], tx_mem[0][40], tx_mem[0][41]}), 64'hC0A80010);

      // announcements for an out-of-range or disabled entry are dropped silently
      snap(0);
      garp_pulse(2'd3);
      repeat (50) @(negedge mac_clk);
      ip_valid = 2'b01;
      garp_pulse(2'd1);
      repeat (50) @(negedge mac_clk);
      ip_valid = 2'b11;
      $display("inst 0 bad announce: xmit=%0d", xmit_cnt[0] - s_xmit);
      check_deltas(0, "tg", 0, 0, 0);

      // reset while building byte 20 aborts without a pulse
      snap(0);
      pr_v[0] = 1'b1;
      begin
         bit seen = 1'b0;
         for (int n = 0; (n < 3000) && !seen; n++) begin
            @(negedge mac_clk);
            if (we_v[0] && (out_addr_v[0] == 6'd19)) seen = 1'b1;
         end
         check("t6_b19_wait", 64'(seen), 64'd1);
      end
      @(negedge mac_clk);
      reset = 1'b1;
      pr_v[0] = 1'b0;
      @(negedge mac_clk);
      check("t6_done", 64'(done_v[0]), 64'd0);
      check("t6_xmit", 64'(xmit_v[0]), 64'd0);
      check("t6_we", 64'(we_v[0]), 64'd0);
      check("t6_out", 64'(out_v[0]), 64'd0);
      check("t6_oaddr", 64'(out_addr_v[0]), 64'd0);
      check("t6_raddr", 64'(rd_addr_v[0]), 64'd0);
      check("t6_ok", 64'(ok_v[0]), 64'd0);
      check("t6_drop", 64'(drop_v[0]), 64'd0);
      reset = 1'b0;
      $display("inst 0 reset in build: we before reset=%0d", we_cnt[0] - s_we);
      check_deltas(0, "t6a", 20, 0, 0);
      run_frame(0);
      check_deltas(0, "t6b", 62, 1, 1);
      check_tx(0, 1'b0);
      check("t6b_ok", 64'(ok_v[0]), 64'd1);
      check("t6b_drop", 64'(drop_v[0]), 64'd0);

      // basic reply with read latency 1 and 4
      for (int i = 1; i < 3; i++) begin
         snap(i);
         run_frame(i);
         check_deltas(i, $sformatf("lat%0d", i), 42, 1, 1);
         check_tx(i, 1'b0);
         check($sformatf("lat%0d_ok", i), 64'(ok_v[i]), 64'd1);
         check($sformatf("lat%0d_drop", i), 64'(drop_v[i]), 64'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
